// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259-compatible PIC bus-side control.
// ICW/OCW field positions follow the 8259 command word layouts.
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } pic_init_state_t;

    localparam logic RD_IRR = 1'b0;
    localparam logic RD_ISR = 1'b1;

    localparam logic [7:0] IMR_RESET = 8'h00;

    localparam int ICW1_IC4   = 0;
    localparam int ICW1_SNGL  = 1;
    localparam int ICW1_LTIM  = 3;
    localparam int ICW1_ID    = 4;
    localparam int ICW2_VB_LSB = 3;
    localparam int ICW4_UPM   = 0;
    localparam int ICW4_AEOI  = 1;
    localparam int OCW3_RIS   = 0;
    localparam int OCW3_RR    = 1;
    localparam int OCW_SEL_LSB = 3;
    localparam int OCW_SEL_MSB = 4;

    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } pic_wr_t;

    // A0=0 with D4 set restarts initialization regardless of current state.
    function automatic logic is_icw1(input pic_wr_t w);
        return !w.a0 && w.data[ICW1_ID];
    endfunction

endpackage

// File: rtl/pic_wr_strobe.sv
// Registers wr_n, holds the bus fields from the last low cycle of the strobe,
// and pulses commit on the cycle wr_n has returned high.
module pic_wr_strobe
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       a0,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic       commit,
    output pic_wr_t    wr
);

    logic    wr_n_q, wr_n_d;
    logic    cs_n_q, cs_n_d;
    pic_wr_t fld_q,  fld_d;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        wr_n_d = wr_n;
        cs_n_d = cs_n_q;
        fld_d  = fld_q;
        if (!wr_n) begin
            cs_n_d = cs_n;
            fld_d  = '{a0: a0, data: din};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q <= 1'b1;
            cs_n_q <= 1'b1;
            fld_q  <= '0;
        end else begin
            wr_n_q <= wr_n_d;
            cs_n_q <= cs_n_d;
            fld_q  <= fld_d;
        end
    end

    assign commit = wr_n && !wr_n_q && !cs_n_q;
    assign wr     = fld_q;

endmodule

// File: rtl/pic_rw_control.sv
// 8259 bus-side read/write control: ICW1-ICW4 initialization sequencing,
// OCW1-OCW3 decode, and registered IRR/ISR/IMR read-back to the data buffer.
module pic_rw_control
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       a0,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic [7:0] imr,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade,
    output logic       aeoi,
    output logic       upm,
    output logic       init_done,
    output logic       ocw2_valid,
    output logic [7:0] ocw2
);

    logic    commit;
    pic_wr_t wr;

    pic_wr_strobe u_wr_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_n   (cs_n),
        .a0     (a0),
        .wr_n   (wr_n),
        .din    (din),
        .commit (commit),
        .wr     (wr)
    );

    pic_init_state_t state_q, state_d;

    logic [7:0] imr_q, imr_d;
    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [4:0] vector_base_q, vector_base_d;
    logic [7:0] cascade_q, cascade_d;
    logic       aeoi_q, aeoi_d;
    logic       upm_q, upm_d;
    logic [7:0] ocw2_q, ocw2_d;
    logic       ocw2_valid_q, ocw2_valid_d;
    logic       read_sel_q, read_sel_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_en_q, dout_en_d;
    logic       rd_active;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_ICW1;
        else        state_q <= state_d;
    end

    // Next-state logic; the ICW2/ICW3 exits use the ICW1 bits latched earlier.
    always_comb begin
        state_d = state_q;
        if (commit) begin
            if (is_icw1(wr)) begin
                state_d = WAIT_ICW2;
            end else if (wr.a0) begin
                case (state_q)
                    WAIT_ICW2: state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
                    WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
                    WAIT_ICW4: state_d = READY;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    // Output logic
    always_comb begin
        init_done = (state_q == READY);
    end

    // A simultaneous write strobe suppresses the read path entirely.
    assign rd_active = !cs_n && !rd_n && wr_n;

    always_comb begin
        imr_d         = imr_q;
        ltim_d        = ltim_q;
        sngl_d        = sngl_q;
        ic4_d         = ic4_q;
        vector_base_d = vector_base_q;
        cascade_d     = cascade_q;
        aeoi_d        = aeoi_q;
        upm_d         = upm_q;
        ocw2_d        = ocw2_q;
        ocw2_valid_d  = 1'b0;
        read_sel_d    = read_sel_q;

        if (commit) begin
            if (is_icw1(wr)) begin
                ltim_d     = wr.data[ICW1_LTIM];
                sngl_d     = wr.data[ICW1_SNGL];
                ic4_d      = wr.data[ICW1_IC4];
                imr_d      = IMR_RESET;
                read_sel_d = RD_IRR;
                if (!wr.data[ICW1_IC4]) begin
                    aeoi_d = 1'b0;
                    upm_d  = 1'b0;
                end
            end else if (wr.a0) begin
                case (state_q)
                    WAIT_ICW2: vector_base_d = wr.data[7:ICW2_VB_LSB];
                    WAIT_ICW3: cascade_d     = wr.data;
                    WAIT_ICW4: begin
                        aeoi_d = wr.data[ICW4_AEOI];
                        upm_d  = wr.data[ICW4_UPM];
                    end
                    READY:     imr_d = wr.data;
                    default:   ;
                endcase
            end else if (state_q == READY) begin
                case (wr.data[OCW_SEL_MSB:OCW_SEL_LSB])
                    OCW_SEL_OCW2: begin
                        ocw2_d       = wr.data;
                        ocw2_valid_d = 1'b1;
                    end
                    OCW_SEL_OCW3: begin
                        if (wr.data[OCW3_RR]) read_sel_d = wr.data[OCW3_RIS];
                    end
                    default: ;
                endcase
            end
        end

        dout_en_d = rd_active;
        dout_d    = 8'h00;
        if (rd_active) begin
            if (a0)                       dout_d = imr_q;
            else if (read_sel_q == RD_ISR) dout_d = isr;
            else                          dout_d = irr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imr_q         <= IMR_RESET;
            ltim_q        <= 1'b0;
            sngl_q        <= 1'b0;
            ic4_q         <= 1'b0;
            vector_base_q <= '0;
            cascade_q     <= '0;
            aeoi_q        <= 1'b0;
            upm_q         <= 1'b0;
            ocw2_q        <= '0;
            ocw2_valid_q  <= 1'b0;
            read_sel_q    <= RD_IRR;
            dout_q        <= '0;
            dout_en_q     <= 1'b0;
        end else begin
            imr_q         <= imr_d;
            ltim_q        <= ltim_d;
            sngl_q        <= sngl_d;
            ic4_q         <= ic4_d;
            vector_base_q <= vector_base_d;
            cascade_q     <= cascade_d;
            aeoi_q        <= aeoi_d;
            upm_q         <= upm_d;
            ocw2_q        <= ocw2_d;
            ocw2_valid_q  <= ocw2_valid_d;
            read_sel_q    <= read_sel_d;
            dout_q        <= dout_d;
            dout_en_q     <= dout_en_d;
        end
    end

    assign dout        = dout_q;
    assign dout_en     = dout_en_q;
    assign imr         = imr_q;
    assign ltim        = ltim_q;
    assign sngl        = sngl_q;
    assign ic4         = ic4_q;
    assign vector_base = vector_base_q;
    assign cascade     = cascade_q;
    assign aeoi        = aeoi_q;
    assign upm         = upm_q;
    assign ocw2        = ocw2_q;
    assign ocw2_valid  = ocw2_valid_q;

endmodule
